// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS-32 front end: opcode constants used by the
// fetch unit and the control decoder, and the fetch state encoding.
package mips_pkg;

  localparam int INSTR_W = 32;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_ISSUE = 2'd2,
    ST_DRAIN = 2'd3
  } fetch_state_t;

  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return addr & ~32'h3;
  endfunction

endpackage

// File: rtl/instr_fetch.sv
// Instruction fetch unit: owns the PC, handshakes with instruction memory and
// presents one instruction at a time to the decoder with stall/redirect/flush.
module instr_fetch
  import mips_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic               clk,
  input  logic               rst_n,
  output logic               imem_req,
  output logic [31:0]        imem_addr,
  input  logic               imem_ack,
  input  logic [INSTR_W-1:0] imem_rdata,
  output logic               instr_valid,
  output logic [INSTR_W-1:0] instr,
  output logic [5:0]         op,
  output logic [5:0]         funct,
  output logic [31:0]        pc,
  output logic               illegal_op,
  input  logic               stall,
  input  logic               branch_taken,
  input  logic [31:0]        branch_target,
  input  logic               flush,
  input  logic [31:0]        flush_pc
);

  fetch_state_t       state, state_d;
  logic [31:0]        fetch_pc, fetch_pc_d;
  logic [31:0]        redirect_pc, redirect_pc_d;
  logic [INSTR_W-1:0] instr_p1, instr_d;
  logic [31:0]        pc_p1, pc_d;

  always_comb begin
    state_d       = state;
    fetch_pc_d    = fetch_pc;
    redirect_pc_d = redirect_pc;
    instr_d       = instr_p1;
    pc_d          = pc_p1;
    case (state)
      ST_IDLE: begin
        state_d = ST_FETCH;
        if (flush) fetch_pc_d = word_align(flush_pc);
      end
      ST_FETCH: begin
        if (flush) begin
          // An ack arriving with the flush closes the old request, so the
          // new address can go out immediately; otherwise it must drain.
          if (imem_ack) begin
            fetch_pc_d = word_align(flush_pc);
          end else begin
            redirect_pc_d = word_align(flush_pc);
            state_d       = ST_DRAIN;
          end
        end else if (imem_ack) begin
          instr_d = imem_rdata;
          pc_d    = fetch_pc;
          state_d = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        if (flush) begin
          fetch_pc_d = word_align(flush_pc);
          state_d    = ST_FETCH;
        end else if (!stall) begin
          fetch_pc_d = branch_taken ? word_align(branch_target) : pc_p1 + 32'd4;
          state_d    = ST_FETCH;
        end
      end
      ST_DRAIN: begin
        if (imem_ack) begin
          fetch_pc_d = flush ? word_align(flush_pc) : redirect_pc;
          state_d    = ST_FETCH;
        end else if (flush) begin
          redirect_pc_d = word_align(flush_pc);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Stage p1: architectural fetch state and the issued instruction
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      fetch_pc    <= word_align(RESET_PC);
      redirect_pc <= word_align(RESET_PC);
      instr_p1    <= '0;
      pc_p1       <= word_align(RESET_PC);
    end else begin
      state       <= state_d;
      fetch_pc    <= fetch_pc_d;
      redirect_pc <= redirect_pc_d;
      instr_p1    <= instr_d;
      pc_p1       <= pc_d;
    end
  end

  assign imem_req    = (state == ST_FETCH) || (state == ST_DRAIN);
  assign imem_addr   = fetch_pc;
  assign instr_valid = (state == ST_ISSUE);
  assign instr       = instr_p1;
  assign pc          = pc_p1;
  assign op          = instr_p1[31:26];
  assign funct       = instr_p1[5:0];
  assign illegal_op  = instr_valid &&
                       !(op == OP_RTYPE || op == OP_LW || op == OP_SW || op == OP_BEQ);

endmodule

// File: tb/tb_instr_fetch.sv
// Bench for instr_fetch: directed scenarios followed by random traffic, all
// checked against a transaction-level model of the fetch unit.
module tb_instr_fetch;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack = 1'b0;
  logic [31:0] imem_rdata = '0;
  logic        instr_valid;
  logic [31:0] instr;
  logic [5:0]  op;
  logic [5:0]  funct;
  logic [31:0] pc;
  logic        illegal_op;
  logic        stall = 1'b0;
  logic        branch_taken = 1'b0;
  logic [31:0] branch_target = '0;
  logic        flush = 1'b0;
  logic [31:0] flush_pc = '0;

  int checks = 0;
  int failures = 0;

  instr_fetch #(.RESET_PC(32'h0000_0000)) dut (
    .clk(clk), .rst_n(rst_n),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .instr_valid(instr_valid), .instr(instr), .op(op), .funct(funct),
    .pc(pc), .illegal_op(illegal_op),
    .stall(stall), .branch_taken(branch_taken), .branch_target(branch_target),
    .flush(flush), .flush_pc(flush_pc)
  );

  always #5 clk = ~clk;

  // Reference model: a pending memory request, an optional remembered
  // redirect, and an optional held instruction.
  bit          m_idle;
  bit          m_req;
  logic [31:0] m_addr;
  bit          m_redir;
  logic [31:0] m_redir_addr;
  bit          m_have;
  logic [31:0] m_instr;
  logic [31:0] m_pc;

  function automatic logic [31:0] al(input logic [31:0] a);
    return {a[31:2], 2'b00};
  endfunction

  task automatic mreset();
    m_idle = 1; m_req = 0; m_addr = 32'h0; m_redir = 0; m_redir_addr = 32'h0;
    m_have = 0; m_instr = 32'h0; m_pc = 32'h0;
  endtask

  task automatic mstep(input bit st, input bit bt, input logic [31:0] tgt,
                       input bit fl, input logic [31:0] fpc, input bit ak,
                       input logic [31:0] rd);
    if (m_idle) begin
      m_idle = 0;
      m_req  = 1;
      if (fl) m_addr = al(fpc);
    end else if (m_have) begin
      if (fl) begin
        m_have = 0; m_req = 1; m_addr = al(fpc);
      end else if (!st) begin
        m_have = 0; m_req = 1; m_addr = bt ? al(tgt) : m_pc + 32'd4;
      end
    end else if (m_req) begin
      if (ak) begin
        if (fl || m_redir) begin
          m_addr  = fl ? al(fpc) : m_redir_addr;
          m_redir = 0;
        end else begin
          m_instr = rd; m_pc = m_addr; m_have = 1; m_req = 0;
        end
      end else if (fl) begin
        m_redir = 1; m_redir_addr = al(fpc);
      end
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic compare_all();
    logic [5:0] eop;
    bit         legal;
    eop   = m_instr[31:26];
    legal = (eop == 6'h00) || (eop == 6'h23) || (eop == 6'h2B) || (eop == 6'h04);
    chk("imem_req", {31'b0, imem_req}, {31'b0, m_req});
    if (m_req) chk("imem_addr", imem_addr, m_addr);
    chk("instr_valid", {31'b0, instr_valid}, {31'b0, m_have});
    chk("instr", instr, m_instr);
    chk("pc", pc, m_pc);
    chk("op", {26'b0, op}, {26'b0, eop});
    chk("funct", {26'b0, funct}, {26'b0, m_instr[5:0]});
    chk("illegal_op", {31'b0, illegal_op}, {31'b0, (m_have && !legal)});
  endtask

  task automatic cyc(input bit st, input bit bt, input logic [31:0] tgt,
                     input bit fl, input logic [31:0] fpc, input bit ak,
                     input logic [31:0] rd);
    stall = st; branch_taken = bt; branch_target = tgt;
    flush = fl; flush_pc = fpc;
    imem_ack = ak & m_req; imem_rdata = rd;
    @(posedge clk);
    mstep(st, bt, tgt, fl, fpc, imem_ack, rd);
    #1;
    compare_all();
  endtask

  logic [5:0] ops [6];

  initial begin
    ops = '{6'h00, 6'h23, 6'h2B, 6'h04, 6'h3F, 6'h02};
    mreset();
    repeat (3) @(posedge clk);
    #1;
    compare_all();
    chk("reset_addr", imem_addr, 32'h0);
    rst_n = 1'b1;

    // Reset release and zero-wait first fetch
    cyc(0, 0, 0, 0, 0, 0, 0);
    chk("first_addr", imem_addr, 32'h0);
    cyc(0, 0, 0, 0, 0, 1, 32'h8C22_0004);
    chk("first_op", {26'b0, op}, {26'b0, 6'b100011});
    chk("first_pc", pc, 32'h0);

    // Three-cycle memory latency, sequential addresses
    cyc(0, 0, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0, 0);
    chk("lat_addr_hold", imem_addr, 32'h4);
    cyc(0, 0, 0, 0, 0, 1, 32'h0000_0020);
    chk("seq_pc4", pc, 32'h4);
    cyc(0, 0, 0, 0, 0, 0, 0);
    chk("seq_addr8", imem_addr, 32'h8);
    cyc(0, 0, 0, 0, 0, 1, 32'h1000_0003);

    // Stall for four cycles; branch_taken during stall is ignored
    for (int i = 0; i < 4; i++) cyc(1, 1, 32'h0000_0200, 0, 0, 1, 32'hDEAD_BEEF);
    chk("stall_pc", pc, 32'h8);
    cyc(0, 1, 32'h0000_0102, 0, 0, 0, 0);
    chk("branch_addr", imem_addr, 32'h0000_0100);

    // Flush while a fetch is outstanding, late ack discarded
    cyc(0, 0, 0, 1, 32'h80, 0, 0);
    cyc(0, 0, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 1, 32'hFFFF_FFFF);
    chk("flush_addr", imem_addr, 32'h80);
    chk("flush_novalid", {31'b0, instr_valid}, 32'h0);

    // Illegal opcode, then PC wrap-around
    cyc(0, 0, 0, 0, 0, 1, 32'hFC00_0000);
    chk("illegal", {31'b0, illegal_op}, 32'h1);
    cyc(0, 0, 0, 1, 32'hFFFF_FFFC, 0, 0);
    cyc(0, 0, 0, 0, 0, 1, 32'h8C22_0004);
    chk("wrap_pc", pc, 32'hFFFF_FFFC);
    cyc(0, 0, 0, 0, 0, 0, 0);
    chk("wrap_addr", imem_addr, 32'h0);

    // Random traffic
    for (int i = 0; i < 1500; i++) begin
      bit          st, bt, fl, ak;
      logic [31:0] tgt, fpc, rd;
      st  = ($urandom % 3) == 0;
      bt  = ($urandom % 4) == 0;
      fl  = ($urandom % 10) == 0;
      ak  = ($urandom % 2) == 0;
      tgt = $urandom;
      fpc = $urandom;
      rd  = {ops[$urandom % 6], 26'($urandom)};
      cyc(st, bt, tgt, fl, fpc, ak, rd);
    end

    // Asynchronous reset while a request is outstanding
    for (int i = 0; i < 4 && !m_req; i++) cyc(0, 0, 0, 0, 0, 0, 0);
    chk("pre_reset_req", {31'b0, imem_req}, 32'h1);
    rst_n = 1'b0;
    #1;
    mreset();
    compare_all();
    chk("async_reset_addr", imem_addr, 32'h0);
    imem_ack = 1'b1; imem_rdata = 32'hFC00_0000;
    stall = 0; flush = 0; branch_taken = 0;
    @(posedge clk);
    #1;
    compare_all();
    rst_n = 1'b1;
    @(posedge clk);
    mstep(0, 0, 0, 0, 0, 1, 32'hFC00_0000);
    #1;
    compare_all();
    cyc(0, 0, 0, 0, 0, 1, 32'h0000_0024);
    chk("post_reset_pc", pc, 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
